// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_pkg
// Description : Shared sample width and sample type for the synthesizer path.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;
    localparam int SAMPLE_W = 12;
    typedef logic [SAMPLE_W-1:0] sample_t;
endpackage
`default_nettype wire

// File: rtl/pwm_counter.sv
`default_nettype none
// ============================================================================
// Module      : pwm_counter
// Description : PWM period counter with wrap detect, comparator and output reg.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_counter
    import synth_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_duty,
    output logic             o_wrap,
    output logic             o_sample_req,
    output logic             o_pwm_out
);
    localparam logic [WIDTH-1:0] c_MAX = '1;

    logic [WIDTH-1:0] r_count;
    logic             r_sample_req;
    logic             r_pwm_out;
    logic             w_wrap;

    assign w_wrap = i_en && (r_count == c_MAX);

    // Counter rolls over naturally at c_MAX, so no explicit clear is needed.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_count      <= '0;
            r_sample_req <= 1'b0;
            r_pwm_out    <= 1'b0;
        end else begin
            if (i_en) begin
                r_count <= r_count + 1'b1;
            end
            r_sample_req <= w_wrap;
            r_pwm_out    <= i_en && (r_count < i_duty);
        end
    end

    assign o_wrap       = w_wrap;
    assign o_sample_req = r_sample_req;
    assign o_pwm_out    = r_pwm_out;
endmodule
`default_nettype wire

// File: rtl/pwm_output.sv
`default_nettype none
// ============================================================================
// Module      : pwm_output
// Description : Audio PWM output stage with one-deep pending sample buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_output
    import synth_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             en,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             sample_req,
    output logic             pwm_out,
    output logic             overrun
);
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_pending;
    logic             r_pend_full;
    logic             r_overrun;
    logic             w_wrap;

    pwm_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk          (clk),
        .nRst         (nRst),
        .i_en         (en),
        .i_duty       (r_duty),
        .o_wrap       (w_wrap),
        .o_sample_req (sample_req),
        .o_pwm_out    (pwm_out)
    );

    // On a boundary the old pending value moves to duty before the new
    // sample (if any) refills the buffer, so a coincident strobe is no loss.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_duty      <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_wrap && r_pend_full) begin
                r_duty <= r_pending;
            end
            if (sample_valid) begin
                r_pending   <= sample;
                r_pend_full <= 1'b1;
            end else if (w_wrap) begin
                r_pend_full <= 1'b0;
            end
            r_overrun <= sample_valid && r_pend_full && !w_wrap;
        end
    end

    assign overrun = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_pwm_output.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_output
// Description : Self-checking bench for pwm_output against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_output;
    localparam int W      = 12;
    localparam int PERIOD = 1 << W;

    logic         clk;
    logic         nRst;
    logic         en;
    logic         sample_valid;
    logic [W-1:0] sample;
    logic         sample_req;
    logic         pwm_out;
    logic         overrun;

    int compared = 0;
    int mismatched = 0;

    // Behavioural reference state
    int m_count;
    int m_duty;
    int m_pend[$];
    bit e_pwm, e_req, e_ovr;

    pwm_output #(.WIDTH(W)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .en           (en),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sample_req   (sample_req),
        .pwm_out      (pwm_out),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_duty  = 0;
        m_pend.delete();
        e_pwm = 0; e_req = 0; e_ovr = 0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check.
    task automatic tick();
        bit boundary;
        @(posedge clk);
        boundary = en && (m_count == PERIOD - 1);
        e_pwm = en && (m_count < m_duty);
        e_req = boundary;
        e_ovr = sample_valid && (m_pend.size() != 0) && !boundary;
        if (boundary && m_pend.size() != 0) m_duty = m_pend.pop_front();
        if (sample_valid) begin
            m_pend.delete();
            m_pend.push_back(int'(sample));
        end
        if (en) m_count = (m_count + 1) % PERIOD;
        #1;
        check("pwm_out", pwm_out, e_pwm);
        check("sample_req", sample_req, e_req);
        check("overrun", overrun, e_ovr);
    endtask

    task automatic strobe(input int value);
        sample_valid = 1'b1;
        sample = W'(value);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (sample_req !== 1'b1 && n < PERIOD + 200) begin
            tick();
            n++;
        end
        check("wait_req_timeout", sample_req, 1'b1);
    endtask

    // Starting on a sample_req cycle, run one period (plus an optional
    // disabled gap at count gap_at) and tally highs and requests.
    task automatic measure(input string tag, input int exp_highs, input int gap_at, input int gap_len);
        int highs = 0;
        int reqs = 0;
        int dut_cnt = 0;
        for (int k = 0; k < PERIOD; k++) begin
            if (k == gap_at) begin
                en = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    if (pwm_out === 1'b1) highs++;
                    if (sample_req === 1'b1) reqs++;
                    check("gap_pwm_low", pwm_out, 1'b0);
                end
                en = 1'b1;
            end
            tick();
            if (pwm_out === 1'b1) highs++;
            if (sample_req === 1'b1) reqs++;
        end
        check_int({tag, "_highs"}, highs, exp_highs);
        check_int({tag, "_reqs"}, reqs, 1);
        dut_cnt = 0;
    endtask

    initial begin
        int n;
        nRst = 1'b0;
        en = 1'b0;
        sample_valid = 1'b0;
        sample = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_pwm", pwm_out, 1'b0);
        check("reset_req", sample_req, 1'b0);
        check("reset_ovr", overrun, 1'b0);
        @(negedge clk);
        nRst = 1'b1;
        @(posedge clk);
        #1;

        // Idle: first request exactly PERIOD cycles after enable, no highs.
        en = 1'b1;
        n = 0;
        while (sample_req !== 1'b1 && n < PERIOD + 200) begin
            tick();
            n++;
        end
        check_int("first_req_latency", n, PERIOD);
        measure("idle", 0, -1, 0);

        // Single sample at count 100.
        repeat (100) tick();
        strobe(1024);
        wait_req();
        measure("duty1024", 1024, -1, 0);

        // Extremes.
        strobe(0);
        wait_req();
        measure("duty0", 0, -1, 0);
        strobe(4095);
        wait_req();
        measure("duty4095", 4095, -1, 0);

        // Coincident strobe on the boundary cycle.
        strobe(2000);
        while (m_count != PERIOD - 1) tick();
        strobe(300);
        check("simul_no_overrun", overrun, 1'b0);
        measure("simul_first", 2000, -1, 0);
        measure("simul_second", 300, -1, 0);

        // Overrun inside one period.
        repeat (10) tick();
        strobe(500);
        check("ovr_first_strobe", overrun, 1'b0);
        repeat (10) tick();
        strobe(600);
        check("ovr_second_strobe", overrun, 1'b1);
        tick();
        check("ovr_one_cycle", overrun, 1'b0);
        wait_req();
        measure("ovr_duty600", 600, -1, 0);

        // Enable gap of 50 cycles at count 1000, then one inside the high region.
        measure("gap1000", 600, 1000, 50);
        measure("gap300", 600, 300, 50);

        // Asynchronous reset in the middle of the high region.
        repeat (200) tick();
        check("pre_reset_high", pwm_out, 1'b1);
        #2;
        nRst = 1'b0;
        #1;
        check("async_pwm", pwm_out, 1'b0);
        check("async_req", sample_req, 1'b0);
        check("async_ovr", overrun, 1'b0);
        model_reset();
        @(negedge clk);
        nRst = 1'b1;
        n = 0;
        while (sample_req !== 1'b1 && n < PERIOD + 200) begin
            tick();
            n++;
        end
        check_int("post_reset_req_latency", n, PERIOD);
        measure("post_reset_duty0", 0, -1, 0);

        // Randomized run against the model.
        for (int i = 0; i < 2 * PERIOD; i++) begin
            en = ($urandom_range(0, 99) < 97);
            sample_valid = ($urandom_range(0, 999) < 3);
            sample = W'($urandom);
            tick();
        end
        sample_valid = 1'b0;
        en = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
